// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction sequencer: state encoding,
// byte width and counter-width helpers.
package spi_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_DONE = 3'd2,
    WAIT_HOST = 3'd3,
    CS_GAP    = 3'd4
  } state_t;

  // Width able to hold the value n itself (byte counts, timer loads).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of a 0-based index below n; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_txn_ctrl_if.sv
// Host-side and byte-master-side handshake bundle of spi_txn_ctrl.
// o_Timeout exists only when SPI_TXN_TIMEOUT_EN is defined.
interface spi_txn_ctrl_if #(parameter int MAX_BYTES_PER_CS = 2);
  import spi_pkg::*;

  localparam int CNT_W = cnt_w(MAX_BYTES_PER_CS);
  localparam int IDX_W = idx_w(MAX_BYTES_PER_CS);

  // Handshake rule: a host byte transfers on a cycle where i_TX_DV and the
  // registered o_TX_Ready are both 1; DV seen while o_TX_Ready=0 is dropped.
  logic [CNT_W-1:0]  i_TX_Count;
  logic [BYTE_W-1:0] i_TX_Byte;
  logic              i_TX_DV;
  logic              o_TX_Ready;
  logic              o_RX_DV;
  logic [BYTE_W-1:0] o_RX_Byte;
  logic [IDX_W-1:0]  o_RX_Count;
  logic [BYTE_W-1:0] o_M_TX_Byte;
  logic              o_M_TX_DV;
  logic              i_M_TX_Ready;
  logic              i_M_RX_DV;
  logic [BYTE_W-1:0] i_M_RX_Byte;
  logic              o_SPI_CS_n;
`ifdef SPI_TXN_TIMEOUT_EN
  logic              o_Timeout;
`endif

  modport master (
    input  i_TX_Count, i_TX_Byte, i_TX_DV, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
    output o_TX_Ready, o_RX_DV, o_RX_Byte, o_RX_Count, o_M_TX_Byte, o_M_TX_DV,
           o_SPI_CS_n
`ifdef SPI_TXN_TIMEOUT_EN
    , output o_Timeout
`endif
  );

  modport slave (
    output i_TX_Count, i_TX_Byte, i_TX_DV, i_M_TX_Ready, i_M_RX_DV, i_M_RX_Byte,
    input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_RX_Count, o_M_TX_Byte, o_M_TX_DV,
           o_SPI_CS_n
`ifdef SPI_TXN_TIMEOUT_EN
    , input o_Timeout
`endif
  );

endinterface

// File: rtl/spi_cs_timer.sv
// Loadable down-counter; o_Done is high whenever the count has reached zero.
module spi_cs_timer #(
  parameter int W = 8
) (
  input  logic         i_Clk,
  input  logic         i_Rst_L,
  input  logic         i_Load,
  input  logic [W-1:0] i_Load_Val,
  output logic         o_Done
);

  logic [W-1:0] cnt;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt <= '0;
    end else if (i_Load) begin
      cnt <= i_Load_Val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign o_Done = (cnt == '0);

endmodule

// File: rtl/spi_txn_ctrl.sv
// Multi-byte SPI transaction sequencer: owns chip select and the byte-master
// DV handshake. Optional WAIT_HOST timeout enabled by SPI_TXN_TIMEOUT_EN.
module spi_txn_ctrl
  import spi_pkg::*;
#(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int CS_INACTIVE_CLKS = 1,
  parameter int TIMEOUT_CLKS     = 255
) (
  input  logic   i_Clk,
  input  logic   i_Rst_L,
  spi_txn_ctrl_if.master bus,
  output state_t o_State
);

  localparam int CNT_W   = cnt_w(MAX_BYTES_PER_CS);
  localparam int IDX_W   = idx_w(MAX_BYTES_PER_CS);
  localparam int TMR_MAX = (CS_INACTIVE_CLKS > TIMEOUT_CLKS) ? CS_INACTIVE_CLKS : TIMEOUT_CLKS;
  localparam int TMR_W   = cnt_w(TMR_MAX);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES_PER_CS);
  localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(CS_INACTIVE_CLKS - 1);

  state_t            state, state_nxt;
  logic [BYTE_W-1:0] pend_byte;
  logic [CNT_W-1:0]  remaining;
  logic [IDX_W-1:0]  rx_idx;
  logic [CNT_W-1:0]  count_sat;
  logic              host_take;
  logic              tmr_load, tmr_done;
  logic [TMR_W-1:0]  tmr_val;

  logic              tx_ready_q, rx_dv_q, m_tx_dv_q, cs_n_q;
  logic [BYTE_W-1:0] rx_byte_q, m_tx_byte_q;
  logic [IDX_W-1:0]  rx_count_q;
`ifdef SPI_TXN_TIMEOUT_EN
  logic              timeout_nxt, timeout_q;
`endif

  assign count_sat = (bus.i_TX_Count > MAX_CNT) ? MAX_CNT : bus.i_TX_Count;
  assign host_take = bus.i_TX_DV && tx_ready_q;

  // One timer serves both the CS-high gap and the WAIT_HOST timeout; it is
  // reloaded on every transition into either state.
  spi_cs_timer #(.W(TMR_W)) u_timer (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Load     (tmr_load),
    .i_Load_Val (tmr_val),
    .o_Done     (tmr_done)
  );

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
`ifdef SPI_TXN_TIMEOUT_EN
    timeout_nxt = 1'b0;
`endif
    case (state)
      IDLE:      if (host_take && count_sat != '0) state_nxt = LOAD;
      LOAD:      if (bus.i_M_TX_Ready) state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.i_M_RX_DV) begin
          if (remaining == '0) begin
            state_nxt = CS_GAP;
            tmr_load  = 1'b1;
            tmr_val   = GAP_LD;
          end else begin
            state_nxt = WAIT_HOST;
`ifdef SPI_TXN_TIMEOUT_EN
            tmr_load  = 1'b1;
            tmr_val   = TMR_W'(TIMEOUT_CLKS - 1);
`endif
          end
        end
      end
      WAIT_HOST: begin
        if (host_take) begin
          state_nxt = LOAD;
        end
`ifdef SPI_TXN_TIMEOUT_EN
        else if (tmr_done) begin
          state_nxt   = CS_GAP;
          tmr_load    = 1'b1;
          tmr_val     = GAP_LD;
          timeout_nxt = 1'b1;
        end
`endif
      end
      CS_GAP:    if (tmr_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      cs_n_q      <= 1'b1;
      tx_ready_q  <= 1'b0;
      m_tx_dv_q   <= 1'b0;
      m_tx_byte_q <= '0;
      rx_dv_q     <= 1'b0;
      rx_byte_q   <= '0;
      rx_count_q  <= '0;
      pend_byte   <= '0;
      remaining   <= '0;
      rx_idx      <= '0;
`ifdef SPI_TXN_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      cs_n_q     <= (state_nxt == IDLE) || (state_nxt == CS_GAP);
      tx_ready_q <= ((state_nxt == IDLE) && bus.i_M_TX_Ready) || (state_nxt == WAIT_HOST);
      m_tx_dv_q  <= (state == LOAD) && bus.i_M_TX_Ready;
      rx_dv_q    <= 1'b0;
`ifdef SPI_TXN_TIMEOUT_EN
      timeout_q  <= timeout_nxt;
`endif
      if (state == IDLE && state_nxt == LOAD) begin
        pend_byte <= bus.i_TX_Byte;
        remaining <= count_sat;
        rx_idx    <= '0;
      end
      if (state == WAIT_HOST && state_nxt == LOAD) pend_byte <= bus.i_TX_Byte;
      if (state == LOAD && bus.i_M_TX_Ready) begin
        m_tx_byte_q <= pend_byte;
        remaining   <= remaining - 1'b1;
      end
      // Index only advances when another byte follows, so it tops out at MAX-1.
      if (state == WAIT_DONE && bus.i_M_RX_DV) begin
        rx_dv_q    <= 1'b1;
        rx_byte_q  <= bus.i_M_RX_Byte;
        rx_count_q <= rx_idx;
        if (remaining != '0) rx_idx <= rx_idx + 1'b1;
      end
    end
  end

  assign bus.o_TX_Ready  = tx_ready_q;
  assign bus.o_RX_DV     = rx_dv_q;
  assign bus.o_RX_Byte   = rx_byte_q;
  assign bus.o_RX_Count  = rx_count_q;
  assign bus.o_M_TX_Byte = m_tx_byte_q;
  assign bus.o_M_TX_DV   = m_tx_dv_q;
  assign bus.o_SPI_CS_n  = cs_n_q;
`ifdef SPI_TXN_TIMEOUT_EN
  assign bus.o_Timeout   = timeout_q;
`endif
  assign o_State         = state;

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Directed bench for spi_txn_ctrl with a loopback byte-master model.
// Define SPI_TXN_TIMEOUT_EN to also exercise the WAIT_HOST timeout.
module tb_spi_txn_ctrl;
  import spi_pkg::*;

  localparam int MAXB = 2;
  localparam int GAP  = 2;
  localparam int TOUT = 8;
  localparam int W    = 9;

  logic   clk;
  logic   rst_n;
  state_t dut_state;

  spi_txn_ctrl_if #(.MAX_BYTES_PER_CS(MAXB)) bus ();

  spi_txn_ctrl #(
    .MAX_BYTES_PER_CS (MAXB),
    .CS_INACTIVE_CLKS (GAP),
    .TIMEOUT_CLKS     (TOUT)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_L (rst_n),
    .bus     (bus),
    .o_State (dut_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- counters / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int m_dv_cnt = 0;
  int cs_fall = 0;
  int cs_viol = 0;
  int dv_viol = 0;
  logic prev_dv = 1'b0;
  logic prev_cs_n = 1'b1;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_q[$];
  logic [7:0]   exp_m_q[$];
  logic [7:0]   m_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- byte-master model (loopback, 4-cycle latency) ----------------
  int   busy_cnt = 0;
  logic [7:0] lat_byte = '0;

  initial begin
    bus.i_M_TX_Ready = 1'b1;
    bus.i_M_RX_DV    = 1'b0;
    bus.i_M_RX_Byte  = '0;
    forever begin
      @(posedge clk); #1;
      bus.i_M_RX_DV = 1'b0;
      if (!rst_n) begin
        bus.i_M_TX_Ready = 1'b1;
        busy_cnt = 0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          bus.i_M_RX_DV    = 1'b1;
          bus.i_M_RX_Byte  = lat_byte;
          bus.i_M_TX_Ready = 1'b1;
        end
      end else if (bus.o_M_TX_DV) begin
        bus.i_M_TX_Ready = 1'b0;
        lat_byte = bus.o_M_TX_Byte;
        busy_cnt = 4;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_M_TX_DV) begin
        m_dv_cnt++;
        m_q.push_back(bus.o_M_TX_Byte);
        if (bus.o_SPI_CS_n) cs_viol++;
        if (prev_dv) dv_viol++;
      end
      if (bus.o_RX_DV) rx_q.push_back({bus.o_RX_Count, bus.o_RX_Byte});
      if (!bus.o_SPI_CS_n && prev_cs_n) cs_fall++;
    end
    prev_dv   = bus.o_M_TX_DV;
    prev_cs_n = bus.o_SPI_CS_n;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input string tag, input logic [1:0] cnt, input logic [7:0] b);
    int guard;
    guard = 0;
    while (bus.o_TX_Ready !== 1'b1 && guard < 100) begin
      tick(1);
      guard++;
    end
    if (guard >= 100) begin
      check({tag, "_ready_timeout"}, 0, 1);
    end else begin
      bus.i_TX_Count = cnt;
      bus.i_TX_Byte  = b;
      bus.i_TX_DV    = 1'b1;
      tick(1);
      bus.i_TX_DV    = 1'b0;
    end
  endtask

  // Pulses DV on a cycle where the controller is not ready.
  task automatic inject_dropped(input string tag, input logic [7:0] b);
    int guard;
    guard = 0;
    while (bus.o_TX_Ready !== 1'b0 && guard < 100) begin
      tick(1);
      guard++;
    end
    if (guard >= 100) begin
      check({tag, "_notready_timeout"}, 0, 1);
    end else begin
      bus.i_TX_Count = 2'd1;
      bus.i_TX_Byte  = b;
      bus.i_TX_DV    = 1'b1;
      tick(1);
      bus.i_TX_DV    = 1'b0;
    end
  endtask

  // Counts cycles with CS high and TX_Ready low after CS rises.
  task automatic measure_gap(input string tag);
    int guard;
    int n;
    guard = 0;
    n = 0;
    @(negedge clk);
    while (bus.o_SPI_CS_n !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      check({tag, "_cs_rise_timeout"}, 0, 1);
    end else begin
      while (bus.o_SPI_CS_n === 1'b1 && bus.o_TX_Ready === 1'b0 && n < 100) begin
        n++;
        @(negedge clk);
      end
      check({tag, "_gap"}, n, GAP);
      check({tag, "_ready_after_gap"}, bus.o_TX_Ready, 1);
    end
    #6;
  endtask

  task automatic drain(input string tag);
    logic [W-1:0] e;
    logic [7:0] em;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_q.size() == 0) check({tag, "_rx_missing"}, 32'hdead, e);
      else check({tag, "_rx"}, rx_q.pop_front(), e);
    end
    check({tag, "_rx_extra"}, rx_q.size(), 0);
    while (exp_m_q.size() > 0) begin
      em = exp_m_q.pop_front();
      if (m_q.size() == 0) check({tag, "_mtx_missing"}, 32'hdead, em);
      else check({tag, "_mtx"}, m_q.pop_front(), em);
    end
    check({tag, "_mtx_extra"}, m_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  int dv0, cf0, guard, n;

  initial begin
    bus.i_TX_Count = '0;
    bus.i_TX_Byte  = '0;
    bus.i_TX_DV    = 1'b0;
    rst_n = 1'b0;
    tick(3);
    check("rst_cs_n", bus.o_SPI_CS_n, 1);
    check("rst_tx_ready", bus.o_TX_Ready, 0);
    check("rst_m_tx_dv", bus.o_M_TX_DV, 0);
    check("rst_m_tx_byte", bus.o_M_TX_Byte, 0);
    check("rst_rx_dv", bus.o_RX_DV, 0);
    check("rst_rx_byte", bus.o_RX_Byte, 0);
    check("rst_rx_count", bus.o_RX_Count, 0);
    check("rst_state", dut_state, IDLE);
    rst_n = 1'b1;
    tick(2);
    check("idle_ready", bus.o_TX_Ready, 1);

    // single byte
    dv0 = m_dv_cnt; cf0 = cs_fall;
    exp_q.push_back({1'b0, 8'hA5}); exp_m_q.push_back(8'hA5);
    send_byte("one", 2'd1, 8'hA5);
    check("one_cs_low", bus.o_SPI_CS_n, 0);
    measure_gap("one");
    check("one_dv_cnt", m_dv_cnt - dv0, 1);
    check("one_cs_fall", cs_fall - cf0, 1);
    drain("one");

    // two bytes, CS continuous
    dv0 = m_dv_cnt; cf0 = cs_fall;
    exp_q.push_back({1'b0, 8'h12}); exp_q.push_back({1'b1, 8'h34});
    exp_m_q.push_back(8'h12); exp_m_q.push_back(8'h34);
    send_byte("two_a", 2'd2, 8'h12);
    send_byte("two_b", 2'd0, 8'h34);
    measure_gap("two");
    check("two_dv_cnt", m_dv_cnt - dv0, 2);
    check("two_cs_fall", cs_fall - cf0, 1);
    drain("two");

    // bytes offered while not ready are dropped
    dv0 = m_dv_cnt; cf0 = cs_fall;
    exp_q.push_back({1'b0, 8'h55}); exp_q.push_back({1'b1, 8'h66});
    exp_m_q.push_back(8'h55); exp_m_q.push_back(8'h66);
    send_byte("hs_a", 2'd2, 8'h55);
    inject_dropped("hs_wd1", 8'hEE);
    inject_dropped("hs_wd2", 8'hEF);
    send_byte("hs_b", 2'd0, 8'h66);
    guard = 0;
    while (bus.o_SPI_CS_n !== 1'b1 && guard < 100) begin tick(1); guard++; end
    check("hs_cs_rise", bus.o_SPI_CS_n, 1);
    inject_dropped("hs_gap", 8'hE0);
    tick(12);
    check("hs_dv_cnt", m_dv_cnt - dv0, 2);
    check("hs_cs_fall", cs_fall - cf0, 1);
    check("hs_state", dut_state, IDLE);
    check("hs_cs_idle", bus.o_SPI_CS_n, 1);
    drain("hs");

    // count = 0 is ignored
    dv0 = m_dv_cnt; cf0 = cs_fall;
    send_byte("zero", 2'd0, 8'h99);
    tick(8);
    check("zero_dv_cnt", m_dv_cnt - dv0, 0);
    check("zero_cs_fall", cs_fall - cf0, 0);
    check("zero_state", dut_state, IDLE);
    drain("zero");

    // count = 3 saturates to 2
    dv0 = m_dv_cnt; cf0 = cs_fall;
    exp_q.push_back({1'b0, 8'hC1}); exp_q.push_back({1'b1, 8'hC2});
    exp_m_q.push_back(8'hC1); exp_m_q.push_back(8'hC2);
    send_byte("sat_a", 2'd3, 8'hC1);
    send_byte("sat_b", 2'd0, 8'hC2);
    measure_gap("sat");
    check("sat_dv_cnt", m_dv_cnt - dv0, 2);
    check("sat_cs_fall", cs_fall - cf0, 1);
    drain("sat");

    // reset in the middle of the first byte of a 2-byte transaction
    exp_m_q.push_back(8'h3C);
    send_byte("rst_a", 2'd2, 8'h3C);
    guard = 0;
    while (bus.i_M_TX_Ready !== 1'b0 && guard < 50) begin tick(1); guard++; end
    check("rstm_busy", bus.i_M_TX_Ready, 0);
    tick(1);
    #2;
    check("rstm_cs_before", bus.o_SPI_CS_n, 0);
    rst_n = 1'b0;
    #1;
    check("rstm_cs_async", bus.o_SPI_CS_n, 1);
    check("rstm_state", dut_state, IDLE);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("rstm_state_after", dut_state, IDLE);
    drain("rstm");
    dv0 = m_dv_cnt; cf0 = cs_fall;
    exp_q.push_back({1'b0, 8'h5A}); exp_m_q.push_back(8'h5A);
    send_byte("rstm_new", 2'd1, 8'h5A);
    measure_gap("rstm_new");
    check("rstm_new_dv_cnt", m_dv_cnt - dv0, 1);
    check("rstm_new_cs_fall", cs_fall - cf0, 1);
    drain("rstm_new");

`ifdef SPI_TXN_TIMEOUT_EN
    exp_q.push_back({1'b0, 8'hAB}); exp_m_q.push_back(8'hAB);
    send_byte("to", 2'd2, 8'hAB);
    guard = 0;
    while (dut_state !== WAIT_HOST && guard < 50) begin tick(1); guard++; end
    check("to_wait_host", dut_state, WAIT_HOST);
    n = 0;
    while (bus.o_Timeout !== 1'b1 && n < 50) begin tick(1); n++; end
    check("to_cycles", n, TOUT);
    check("to_cs_high", bus.o_SPI_CS_n, 1);
    tick(1);
    check("to_pulse_one", bus.o_Timeout, 0);
    tick(GAP + 1);
    check("to_state_idle", dut_state, IDLE);
    drain("to");
`endif

    check("no_b2b_dv", dv_viol, 0);
    check("cs_leads_dv", cs_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_txn_ctrl.md
Name: spi_txn_ctrl

Overview:
- Transaction sequencer that sits directly upstream of the byte-level SPI master.
- Accepts a multi-byte transaction from the host side: a byte count, then that many bytes.
- Drives the master's byte/DV handshake and owns the active-low chip select, keeping it low across every byte of the transaction.
- Returns received bytes tagged with their index and enforces a minimum CS-high gap between transactions.

Parameters:
MAX_BYTES_PER_CS, 2, max bytes in one CS-low transaction (>=1)
CS_INACTIVE_CLKS, 1, i_Clk cycles CS held high after last byte before next transaction may start (>=1)
TIMEOUT_CLKS, 255, idle-wait limit inside a transaction; used only with SPI_TXN_TIMEOUT_EN

Ports:
i_Clk  in  1  system clock
i_Rst_L  in  1  asynchronous active-low reset
i_TX_Count  in  $clog2(MAX_BYTES_PER_CS+1)  byte count; sampled only with the first byte of a transaction
i_TX_Byte  in  8  host byte
i_TX_DV  in  1  host byte-valid pulse
o_TX_Ready  out  1  controller can accept a host byte this cycle
o_RX_DV  out  1  one-cycle pulse, received byte valid
o_RX_Byte  out  8  received byte
o_RX_Count  out  $clog2(MAX_BYTES_PER_CS)  0-based index of o_RX_Byte within the transaction
o_M_TX_Byte  out  8  byte to master
o_M_TX_DV  out  1  one-cycle DV pulse to master
i_M_TX_Ready  in  1  master ready
i_M_RX_DV  in  1  master RX byte-done pulse
i_M_RX_Byte  in  8  master RX byte
o_SPI_CS_n  out  1  chip select, active low

Behaviour:
- All outputs registered.
- Reset values: o_SPI_CS_n=1, o_TX_Ready=0, o_M_TX_DV=0, o_M_TX_Byte=0, o_RX_DV=0, o_RX_Byte=0, o_RX_Count=0. State=IDLE.
- Reset mid-transaction aborts immediately; CS goes high asynchronously.
- FSM states: IDLE, LOAD, WAIT_DONE, WAIT_HOST, CS_GAP.
- IDLE:
  - o_TX_Ready=1 while i_M_TX_Ready=1.
  - i_TX_DV with i_TX_Count!=0: latch byte into the pending register, latch count, clear RX index, drive CS_n=0 next cycle, go to LOAD.
  - i_TX_DV with i_TX_Count=0 is ignored; state stays IDLE.
- LOAD:
  - When i_M_TX_Ready=1, pulse o_M_TX_DV one cycle with the pending byte, decrement remaining, go to WAIT_DONE.
  - CS_n is already low on the o_M_TX_DV cycle, so CS leads the first SCLK edge.
- WAIT_DONE:
  - o_TX_Ready=0.
  - On i_M_RX_DV: register o_RX_Byte=i_M_RX_Byte, pulse o_RX_DV (1-cycle latency), o_RX_Count=current index, then index+1.
  - If remaining==0, go to CS_GAP; else go to WAIT_HOST.
- WAIT_HOST:
  - o_TX_Ready=1; CS stays low.
  - i_TX_DV: latch byte (i_TX_Count ignored), go to LOAD.
- CS_GAP:
  - CS_n=1 and o_TX_Ready=0 for exactly CS_INACTIVE_CLKS cycles, then IDLE.
- i_TX_DV while o_TX_Ready=0 is dropped and must not disturb state.
- o_M_TX_DV is never asserted on two consecutive cycles and never while i_M_TX_Ready=0.
- i_M_RX_DV outside WAIT_DONE is ignored.
- i_TX_Count > MAX_BYTES_PER_CS is saturated to MAX_BYTES_PER_CS.
- Remaining-byte counter width is $clog2(MAX_BYTES_PER_CS+1) and never wraps.
- o_RX_Count wraps never: max value is MAX_BYTES_PER_CS-1.

Optional Feature:
- SPI_TXN_TIMEOUT_EN defined:
  - In WAIT_HOST a counter increments each cycle.
  - On reaching TIMEOUT_CLKS: abort the transaction, go to CS_GAP (CS_n=1), and pulse output port o_Timeout for one cycle.
  - The counter clears on entry to WAIT_HOST.
- Not defined: no counter and no o_Timeout port; WAIT_HOST holds CS low indefinitely.

Decomposition:
- Shared package spi_pkg holds:
  - FSM state encoding (3-bit localparams).
  - The byte width constant (8).
  - The count-width helper expression.
- One natural sub-module: spi_cs_timer.
  - Loadable down-counter with a done flag.
  - Reused for the CS_GAP delay and the optional timeout.

Test Plan:
- Single byte: count=1, byte 0xA5, master model loops MOSI to MISO → one o_M_TX_DV with 0xA5; CS low before it; o_RX_Byte=0xA5, o_RX_Count=0; CS high for exactly CS_INACTIVE_CLKS before o_TX_Ready=1.
- Two bytes: count=2, bytes 0x12 then 0x34 → CS low continuously across both; RX 0x12 idx0 then 0x34 idx1; exactly two o_M_TX_DV pulses.
- Handshake: i_TX_DV held off/injected while o_TX_Ready=0 (WAIT_DONE, CS_GAP) → byte dropped, no extra o_M_TX_DV, transaction counts unchanged.
- Boundaries:
  - count=0 → no CS activity.
  - count=3 with MAX=2 → exactly 2 bytes sent, then CS_GAP.
- Reset: assert i_Rst_L=0 mid-byte of a 2-byte transaction → CS_n=1 asynchronously; after release, state IDLE and a new 1-byte transaction completes normally.
- With SPI_TXN_TIMEOUT_EN, TIMEOUT_CLKS=8: count=2, send first byte, withhold second → o_Timeout pulse 8 cycles after entering WAIT_HOST, CS_n=1, then IDLE.
